// File: rtl/round_checker_if.sv
// Run/busy handshake with the compute block plus the two SRAM read ports
// (output and golden) that round_checker drives during the compare phase.
interface round_checker_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 16
);
    logic                  dut_run;
    logic                  dut_busy;
    logic [ADDR_WIDTH-1:0] output_sram_read_address;
    logic [DATA_WIDTH-1:0] output_sram_read_data;
    logic [ADDR_WIDTH-1:0] golden_sram_read_address;
    logic [DATA_WIDTH-1:0] golden_sram_read_data;

    // Checker side: requests runs and drives both read addresses.
    modport master (
        output dut_run,
        output output_sram_read_address,
        output golden_sram_read_address,
        input  dut_busy,
        input  output_sram_read_data,
        input  golden_sram_read_data
    );

    // Compute block / SRAM side.
    modport slave (
        input  dut_run,
        input  output_sram_read_address,
        input  golden_sram_read_address,
        output dut_busy,
        output output_sram_read_data,
        output golden_sram_read_data
    );
endinterface

// File: rtl/round_checker.sv
// Run-and-check controller: starts one compute round, times it, then reads the
// output SRAM back against a golden SRAM and reports match statistics.
module round_checker #(
    parameter int ADDR_WIDTH     = 12,
    parameter int DATA_WIDTH     = 16,
    parameter int CNT_WIDTH      = 32,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   num_results,
    input  logic [ADDR_WIDTH-1:0] result_base,
    input  logic [ADDR_WIDTH-1:0] golden_base,
    round_checker_if.master       bus,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic                  timeout,
    output logic [ADDR_WIDTH:0]   correct_count,
    output logic [ADDR_WIDTH:0]   first_mismatch_idx,
    output logic [CNT_WIDTH-1:0]  compute_cycles
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_IDLE,
        S_RUN,
        S_COMPUTE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [CNT_WIDTH-1:0]  TIMEOUT_LIMIT = CNT_WIDTH'(TIMEOUT_CYCLES);
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE       = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0]   IDX_ONE       = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE      = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0]   IDX_NONE      = '1;

    state_t                state_reg, state_next;

    logic [ADDR_WIDTH:0]   num_reg;
    logic [ADDR_WIDTH-1:0] result_base_reg;
    logic [ADDR_WIDTH-1:0] golden_base_reg;
    logic [ADDR_WIDTH:0]   idx_reg;
    logic [ADDR_WIDTH-1:0] out_addr_reg;
    logic [ADDR_WIDTH-1:0] gold_addr_reg;
    logic                  cmp_valid_reg;
    logic [ADDR_WIDTH:0]   cmp_idx_reg;
    logic [ADDR_WIDTH:0]   correct_reg;
    logic [ADDR_WIDTH:0]   first_mismatch_reg;
    logic [CNT_WIDTH-1:0]  cycles_reg;
    logic                  timeout_reg;
    logic                  run_reg;

    logic [CNT_WIDTH-1:0]  cycles_inc;
    logic                  hit_limit;
    logic                  last_idx;
    logic                  accept_start;
    logic                  timeout_hit;
    logic                  counting;
    logic                  word_match;
    logic [DATA_WIDTH-1:0] bit_eq;

    assign cycles_inc   = cycles_reg + CNT_ONE;
    assign hit_limit    = (cycles_inc == TIMEOUT_LIMIT);
    assign last_idx     = (idx_reg == (num_reg - IDX_ONE));
    assign accept_start = start && ((state_reg == S_IDLE) || (state_reg == S_DONE));
    assign counting     = (state_reg == S_RUN) || (state_reg == S_COMPUTE);

    // Per-bit equality of the returned words; the word matches only if every bit does.
    for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_bit_eq
        assign bit_eq[gi] = ~(bus.output_sram_read_data[gi] ^ bus.golden_sram_read_data[gi]);
    end
    assign word_match = &bit_eq;

    always_comb begin
        state_next  = state_reg;
        timeout_hit = 1'b0;
        case (state_reg)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_next = S_WAIT_IDLE;
                end
            end
            S_WAIT_IDLE: begin
                if (!bus.dut_busy) begin
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (hit_limit) begin
                    state_next  = S_DONE;
                    timeout_hit = 1'b1;
                end else if (bus.dut_busy) begin
                    state_next = S_COMPUTE;
                end
            end
            S_COMPUTE: begin
                // A finished DUT wins over a limit reached on the same edge.
                if (!bus.dut_busy) begin
                    state_next = (num_reg == '0) ? S_DONE : S_READ;
                end else if (hit_limit) begin
                    state_next  = S_DONE;
                    timeout_hit = 1'b1;
                end
            end
            S_READ: begin
                if (last_idx) begin
                    state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                state_next = S_DONE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg          <= S_IDLE;
            num_reg            <= '0;
            result_base_reg    <= '0;
            golden_base_reg    <= '0;
            idx_reg            <= '0;
            out_addr_reg       <= '0;
            gold_addr_reg      <= '0;
            cmp_valid_reg      <= 1'b0;
            cmp_idx_reg        <= '0;
            correct_reg        <= '0;
            first_mismatch_reg <= IDX_NONE;
            cycles_reg         <= '0;
            timeout_reg        <= 1'b0;
            run_reg            <= 1'b0;
        end else begin
            state_reg <= state_next;
            // Run request stays up through the first COMPUTE cycle, then drops.
            run_reg   <= (state_next == S_RUN) ||
                         ((state_reg == S_RUN) && (state_next == S_COMPUTE));

            if (accept_start) begin
                num_reg            <= num_results;
                result_base_reg    <= result_base;
                golden_base_reg    <= golden_base;
                correct_reg        <= '0;
                first_mismatch_reg <= IDX_NONE;
                cycles_reg         <= '0;
                timeout_reg        <= 1'b0;
            end

            if (counting) begin
                cycles_reg <= cycles_inc;
            end
            if (timeout_hit) begin
                timeout_reg <= 1'b1;
            end

            // Addresses only move inside READ and wrap naturally at the address width.
            if ((state_reg == S_COMPUTE) && (state_next == S_READ)) begin
                out_addr_reg  <= result_base_reg;
                gold_addr_reg <= golden_base_reg;
                idx_reg       <= '0;
            end else if ((state_reg == S_READ) && !last_idx) begin
                out_addr_reg  <= out_addr_reg + ADDR_ONE;
                gold_addr_reg <= gold_addr_reg + ADDR_ONE;
                idx_reg       <= idx_reg + IDX_ONE;
            end

            cmp_valid_reg <= (state_reg == S_READ);
            cmp_idx_reg   <= idx_reg;

            if (cmp_valid_reg) begin
                if (word_match) begin
                    correct_reg <= correct_reg + IDX_ONE;
                end else if (first_mismatch_reg == IDX_NONE) begin
                    first_mismatch_reg <= cmp_idx_reg;
                end
            end
        end
    end

    assign bus.dut_run                  = run_reg;
    assign bus.output_sram_read_address = out_addr_reg;
    assign bus.golden_sram_read_address = gold_addr_reg;

    assign busy               = (state_reg != S_IDLE) && (state_reg != S_DONE);
    assign done               = (state_reg == S_DONE);
    assign pass               = done && !timeout_reg && (correct_reg == num_reg);
    assign timeout            = timeout_reg;
    assign correct_count      = correct_reg;
    assign first_mismatch_idx = first_mismatch_reg;
    assign compute_cycles     = cycles_reg;

endmodule
